fifo_bank_dw_fwft: RTL

//  Parametrised successor of fifo_bank: synchronous first-word-fall-through FIFO on one single-port RAM

---
 rtl/fifo_bank_dw_fwft.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fifo_bank_dw_fwft.sv
// fifo_bank_dw_fwft: FWFT FIFO packing word pairs into one 2W-wide single-port RAM, with count, almost flags, flush and sticky errors
module fifo_bank_dw_fwft #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  full_o,
  output logic                  almost_full_o,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty_o,
  output logic                  almost_empty_o,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH / 2);
  logic [2*DW-1:0] mem [FIFO_DEPTH/2];
  logic [AW:0] wptr, rptr;
  logic [DW-1:0] rb [2], rb_n [2], uq [4];
  logic [1:0] rcnt, rn;
  logic [DW-1:0] wst, wst_n;
  logic wst_v, wst_v_n;
  logic [2*DW-1:0] wpair, wpair_n, wr_data, rd_pair;
  logic wpair_v, wpair_v_n;
  logic [2:0] un, k, ln;
  logic push, pop, ram_empty, rd, wr;
  logic [CNT_WIDTH-1:0] cnt_n;
  function automatic logic [AW:0] inc(input logic [AW:0] p);
    return p[AW-1:0] == AW'(FIFO_DEPTH / 2 - 1) ? {~p[AW], {AW{1'b0}}} : p + 1'b1;
  endfunction
  assign push = wen & ~full_o;
  assign pop = ren & ~empty_o;
  assign ram_empty = wptr == rptr;
  assign rd_pair = mem[rptr[AW-1:0]];
  assign rdata = rb[0];
  assign cnt_n = count_o + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
  // Word order is read buffer, RAM, pending pair, odd word, incoming word; refills never reorder it.
  always_comb begin
    rb_n = rb;
    rn = rcnt - {1'b0, pop};
    if (pop && rcnt == 2'd2) rb_n[0] = rb[1];
    uq = '{default: '0};
    un = 3'd0;
    if (wpair_v) begin
      uq[0] = wpair[DW-1:0];
      uq[1] = wpair[2*DW-1:DW];
      un = 3'd2;
    end
    if (wst_v) begin
      uq[un[1:0]] = wst;
      un = un + 3'd1;
    end
    if (push) begin
      uq[un[1:0]] = wdata;
      un = un + 3'd1;
    end
    rd = ~ram_empty && rn == 2'd0;
    if (rd) begin
      rb_n[0] = rd_pair[DW-1:0];
      rb_n[1] = rd_pair[2*DW-1:DW];
      rn = 2'd2;
    end
    k = 3'd0;
    for (int i = 0; i < 2; i++)
      if (ram_empty && rn != 2'd2 && k < un) begin
        rb_n[rn[0]] = uq[k[1:0]];
        rn = rn + 2'd1;
        k = k + 3'd1;
      end
    ln = un - k;
    wr = ~rd && ln >= 3'd2;
    wr_data = {uq[2'(k + 3'd1)], uq[k[1:0]]};
    k = wr ? k + 3'd2 : k;
    ln = wr ? ln - 3'd2 : ln;
    wpair_v_n = ln >= 3'd2;
    wpair_n = {uq[2'(k + 3'd1)], uq[k[1:0]]};
    wst_v_n = ln[0];
    wst_n = ln >= 3'd2 ? uq[2'(k + 3'd2)] : uq[k[1:0]];
  end
  always_ff @(posedge clk)
    if (wr && !rst && !flush) mem[wptr[AW-1:0]] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
      rb <= '{default: '0};
      rcnt <= '0;
      wst <= '0;
      wst_v <= 1'b0;
      wpair <= '0;
      wpair_v <= 1'b0;
      count_o <= '0;
      empty_o <= 1'b1;
      full_o <= 1'b0;
      almost_empty_o <= 1'b1;
      almost_full_o <= 1'b0;
    end else begin
      wptr <= wr ? inc(wptr) : wptr;
      rptr <= rd ? inc(rptr) : rptr;
      rb <= rb_n;
      rcnt <= rn;
      wst <= wst_n;
      wst_v <= wst_v_n;
      wpair <= wpair_n;
      wpair_v <= wpair_v_n;
      count_o <= cnt_n;
      empty_o <= cnt_n == '0;
      full_o <= cnt_n == CNT_WIDTH'(FIFO_DEPTH);
      almost_empty_o <= cnt_n <= CNT_WIDTH'(AE_LEVEL);
      almost_full_o <= cnt_n >= CNT_WIDTH'(AF_LEVEL);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_o <= 1'b0;
      underflow_o <= 1'b0;
    end else if (!flush) begin
      overflow_o <= overflow_o | (wen & full_o);
      underflow_o <= underflow_o | (ren & empty_o);
    end
  end
endmodule
